polar_encoder_pipe: RTL and testbench



---
 rtl/polar_encoder_pipe_pkg.sv | 37 +++
 rtl/polar_butterfly_stage.sv | 43 ++++
 rtl/polar_encoder_pipe.sv | 95 +++++++++
 tb/tb_polar_encoder_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_encoder_pipe_pkg.sv
// Shared constants and mask helpers for the pipelined polar encoder.
// A frozen mask is indexed [0:N-1] with position 0 as the leftmost bit of
// its literal. Widened into a mask_t, position j therefore sits at bit N-1-j.
package polar_encoder_pipe_pkg;

  localparam int MAX_N_LOG2 = 10;
  localparam int MAX_N      = 1 << MAX_N_LOG2;

  // Default code: N = 8, four information bits on positions 3, 5, 6 and 7.
  localparam int              DEF_N_LOG2      = 3;
  localparam int              DEF_N           = 1 << DEF_N_LOG2;
  localparam int              MESSAGE_LENGTH  = 4;
  localparam logic [0:DEF_N-1] DEF_FROZEN_MASK = 8'b1110_1000;

  typedef logic [MAX_N-1:0] mask_t;

  // True when position j of an n-bit mask is frozen.
  function automatic bit is_frozen(input mask_t mask, input int n, input int j);
    return mask[MAX_N_LOG2'(n - 1 - j)];
  endfunction

  // Number of information positions strictly below j.
  // For an information position this is the info bit index it receives.
  function automatic int zeros_before(input mask_t mask, input int n, input int j);
    int cnt = 0;
    for (int i = 0; i < j; i++) begin
      if (!is_frozen(mask, n, i)) cnt++;
    end
    return cnt;
  endfunction

  // Total number of information positions in an n-bit mask.
  function automatic int count_info(input mask_t mask, input int n);
    return zeros_before(mask, n, n);
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One registered butterfly level of the polar transform.
// At distance D = 2^(STAGE-1) each pair (j, j+D) with bit D of j clear
// becomes (u[j] ^ u[j+D], u[j+D]). Natural order, no bit reversal.
module polar_butterfly_stage #(
  parameter int N     = 8,
  parameter int STAGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         src_valid,
  input  logic [0:N-1] src,
  output logic         valid,
  output logic [0:N-1] data
);

  localparam int D = 1 << (STAGE - 1);

  logic [0:N-1] mixed;

  // j | D stays inside 0..N-1 because N is a power of two above D.
  for (genvar j = 0; j < N; j++) begin : g_bfly
    if ((j & D) == 0) begin : g_upper
      assign mixed[j] = src[j] ^ src[j | D];
    end else begin : g_lower
      assign mixed[j] = src[j];
    end
  end

  // Load the butterfly result when the pipeline advances, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    if (rst) begin
      valid <= 1'b0;
      // NOTE: data registers are reset as well so encoded_o reads 0 after reset, not X.
      data  <= '0;
    end else if (en) begin
      valid <= src_valid;
      data  <= mixed;
    end
  end

endmodule

// File: rtl/polar_encoder_pipe.sv
// Pipelined polar encoder: maps K information bits onto the non-frozen
// positions of u, then computes x = u * F^(xn) over N_LOG2 registered
// butterfly levels. The whole pipeline advances together whenever the output
// register is empty or being drained, so bubbles are carried, not squeezed.
module polar_encoder_pipe
  import polar_encoder_pipe_pkg::*;
#(
  parameter int                        N_LOG2      = DEF_N_LOG2,
  parameter int                        K           = MESSAGE_LENGTH,
  parameter logic [0:(1<<N_LOG2)-1]    FROZEN_MASK = DEF_FROZEN_MASK,
  parameter int                        CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     info_valid_i,
  output logic                     info_ready_o,
  input  logic [0:K-1]             info_i,
  output logic                     enc_valid_o,
  input  logic                     enc_ready_i,
  output logic [0:(1<<N_LOG2)-1]   encoded_o,
  output logic [CNT_W-1:0]         frame_cnt_o
);

  localparam int    N      = 1 << N_LOG2;
  localparam mask_t MASK_V = mask_t'(FROZEN_MASK);

  // Illegal parameter sets are rejected at elaboration.
  if (N_LOG2 < 1 || N_LOG2 > MAX_N_LOG2) begin : g_bad_n_log2
    $error("polar_encoder_pipe: N_LOG2 must be in 1..10");
  end
  if (K < 1 || K > N || count_info(MASK_V, N) != K) begin : g_bad_k
    $error("polar_encoder_pipe: FROZEN_MASK must contain exactly K zeros, 1 <= K <= N");
  end

  logic                    adv;
  logic [0:N-1]            mapped;
  logic                    s0_valid;
  logic [0:N-1]            s0_data;
  logic [N_LOG2:0]         chain_valid;
  logic [N_LOG2:0][0:N-1]  chain_data;

  assign adv          = !enc_valid_o || enc_ready_i;
  assign info_ready_o = adv;

  // Frozen positions are tied to 0; the k-th information position gets info_i[k].
  for (genvar j = 0; j < N; j++) begin : g_map
    if (is_frozen(MASK_V, N, j)) begin : g_frozen
      assign mapped[j] = 1'b0;
    end else begin : g_info
      assign mapped[j] = info_i[zeros_before(MASK_V, N, j)];
    end
  end

  // Stage 0 captures the mapped vector u; its valid follows info_valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else if (adv) begin
      s0_valid <= info_valid_i;
      s0_data  <= mapped;
    end
  end

  assign chain_valid[0] = s0_valid;
  assign chain_data[0]  = s0_data;

  for (genvar s = 1; s <= N_LOG2; s++) begin : g_stage
    polar_butterfly_stage #(
      .N     (N),
      .STAGE (s)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .src_valid (chain_valid[s-1]),
      .src       (chain_data[s-1]),
      .valid     (chain_valid[s]),
      .data      (chain_data[s])
    );
  end

  assign enc_valid_o = chain_valid[N_LOG2];
  assign encoded_o   = chain_data[N_LOG2];

  // Count delivered frames; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
    end else if (enc_valid_o && enc_ready_i) begin
      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_polar_encoder_pipe.sv
// Self-checking bench for polar_encoder_pipe: a default N=8 instance and an
// N=16 instance with a 4-bit frame counter, each tracked by its own
// scoreboard fed from a superset-XOR reference of the polar transform.
module tb_polar_encoder_pipe;

  localparam logic [0:7]  MASK_A = 8'b1110_1000;
  localparam logic [0:15] MASK_B = 16'b1111_1110_1000_0000;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_enc_valid, a_enc_ready;
  logic [0:3]  a_info;
  logic [0:7]  a_enc;
  logic [15:0] a_cnt;

  logic        b_in_valid, b_in_ready, b_enc_valid, b_enc_ready;
  logic [0:7]  b_info;
  logic [0:15] b_enc;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  polar_encoder_pipe dut_a (
    .clk          (clk),
    .rst          (rst),
    .info_valid_i (a_in_valid),
    .info_ready_o (a_in_ready),
    .info_i       (a_info),
    .enc_valid_o  (a_enc_valid),
    .enc_ready_i  (a_enc_ready),
    .encoded_o    (a_enc),
    .frame_cnt_o  (a_cnt)
  );

  polar_encoder_pipe #(
    .N_LOG2      (4),
    .K           (8),
    .FROZEN_MASK (MASK_B),
    .CNT_W       (4)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .info_valid_i (b_in_valid),
    .info_ready_o (b_in_ready),
    .info_i       (b_info),
    .enc_valid_o  (b_enc_valid),
    .enc_ready_i  (b_enc_ready),
    .encoded_o    (b_enc),
    .frame_cnt_o  (b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: u from the mask's zero positions, then x_j = XOR of u_i over
  // every i whose bit set contains j. Vectors are left-aligned in 16 bits.
  function automatic logic [0:15] ref_encode(input int nlog, input logic [0:15] mask,
                                             input logic [0:15] info);
    int          n = 1 << nlog;
    int          k = 0;
    logic [0:15] u = '0;
    logic [0:15] x = '0;
    for (int j = 0; j < n; j++) begin
      if (!mask[j]) begin
        u[j] = info[k];
        k++;
      end
    end
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  // ---------------- scoreboard A ----------------
  logic [0:7]  qa[$];
  int          a_cnt_model;
  bit          a_stalled;
  logic [0:7]  a_held, a_exp;
  logic [0:15] a_ref;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      a_cnt_model = 0;
      a_stalled   = 1'b0;
    end else begin
      check("a_cnt", a_cnt, a_cnt_model);
      if (a_stalled) begin
        check("a_stall_data", a_enc, a_held);
        check("a_stall_valid", a_enc_valid, 1'b1);
      end
      if (a_enc_valid && !a_enc_ready) check("a_ready_low", a_in_ready, 1'b0);
      if (a_enc_valid && a_enc_ready) begin
        check("a_out_expected", qa.size() != 0, 1'b1);
        if (qa.size() != 0) begin
          a_exp = qa.pop_front();
          check("a_data", a_enc, a_exp);
        end
        a_cnt_model = (a_cnt_model + 1) % 65536;
      end
      if (a_in_valid && a_in_ready) begin
        a_ref = ref_encode(3, {MASK_A, 8'h00}, {a_info, 12'h000});
        a_exp = a_ref[0:7];
        qa.push_back(a_exp);
      end
      a_stalled = a_enc_valid && !a_enc_ready;
      a_held    = a_enc;
    end
  end

  // ---------------- scoreboard B ----------------
  logic [0:15] qb[$];
  int          b_cnt_model;
  bit          b_stalled;
  logic [0:15] b_held, b_exp;

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      b_cnt_model = 0;
      b_stalled   = 1'b0;
    end else begin
      check("b_cnt", b_cnt, b_cnt_model);
      if (b_stalled) begin
        check("b_stall_data", b_enc, b_held);
        check("b_stall_valid", b_enc_valid, 1'b1);
      end
      if (b_enc_valid && !b_enc_ready) check("b_ready_low", b_in_ready, 1'b0);
      if (b_enc_valid && b_enc_ready) begin
        check("b_out_expected", qb.size() != 0, 1'b1);
        if (qb.size() != 0) begin
          b_exp = qb.pop_front();
          check("b_data", b_enc, b_exp);
        end
        b_cnt_model = (b_cnt_model + 1) % 16;
      end
      if (b_in_valid && b_in_ready) begin
        b_exp = ref_encode(4, MASK_B, {b_info, 8'h00});
        qb.push_back(b_exp);
      end
      b_stalled = b_enc_valid && !b_enc_ready;
      b_held    = b_enc;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One frame into an idle pipeline A; checks the 4-edge latency and the codeword.
  task automatic directed_a(input string tag, input logic [0:3] info, input logic [0:7] exp);
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_info     = info;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check({tag, "_early"}, a_enc_valid, 1'b0);
    @(posedge clk);
    #1 check({tag, "_valid"}, a_enc_valid, 1'b1);
    check({tag, "_data"}, a_enc, exp);
  endtask

  initial begin
    int sent;
    int cyc;

    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_info      = '0;
    a_enc_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_info      = '0;
    b_enc_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    check("a_rst_valid", a_enc_valid, 1'b0);
    check("a_rst_data",  a_enc, 8'h00);
    check("a_rst_cnt",   a_cnt, 16'h0000);
    check("a_rst_ready", a_in_ready, 1'b1);
    check("b_rst_valid", b_enc_valid, 1'b0);
    check("b_rst_data",  b_enc, 16'h0000);
    check("b_rst_cnt",   b_cnt, 4'h0);
    check("b_rst_ready", b_in_ready, 1'b1);

    // Known codewords for the default code.
    directed_a("a_1111", 4'b1111, 8'b0110_1001);
    directed_a("a_1000", 4'b1000, 8'b1111_0000);
    directed_a("a_0001", 4'b0001, 8'b1111_1111);
    directed_a("a_0000", 4'b0000, 8'b0000_0000);

    // All 16 info words back-to-back with the sink always ready.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_info     = 4'(i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("a_b2b_last_valid", a_enc_valid, 1'b1);
    @(posedge clk);
    #1 check("a_b2b_cnt", a_cnt, 16'd16);
    check("a_b2b_empty", a_enc_valid, 1'b0);

    // 200 random frames with a randomly stalling sink.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      @(posedge clk); #1;
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_info      = 4'($urandom);
      a_enc_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_in_valid && a_in_ready) sent++;
      cyc++;
    end
    check("a_rand_sent", sent, 200);
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_enc_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("a_rand_drained", qa.size(), 0);
    check("a_rand_cnt", a_cnt, 16'd200);

    // Reset with three frames in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_info     = 4'($urandom);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1 check("a_midrst_valid", a_enc_valid, 1'b0);
    check("a_midrst_cnt", a_cnt, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("a_no_stale", a_enc_valid, 1'b0);
    end
    check("a_no_stale_cnt", a_cnt, 16'h0000);

    // Wider instance: random traffic against the model.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 3000) begin
      @(posedge clk); #1;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_info      = 8'($urandom);
      b_enc_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_in_valid && b_in_ready) sent++;
      cyc++;
    end
    check("b_rand_sent", sent, 100);
    @(posedge clk); #1;
    b_in_valid  = 1'b0;
    b_enc_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("b_rand_drained", qb.size(), 0);
    check("b_rand_cnt", b_cnt, 4'(100 % 16));

    // 17 frames wrap the 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      b_in_valid = 1'b1;
      b_info     = 8'($urandom);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("b_wrap_cnt", b_cnt, 4'd1);
    check("b_wrap_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
